// File: rtl/selection_sort_sequencer.sv
// Selection-sort sequencer: drives a single-port RAM (1-cycle read latency)
// through an in-place ascending selection sort and counts compares/swaps.
module selection_sort_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SIGNED     = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [31:0]           cmp_cnt,
  output logic [31:0]           swap_cnt
);

  // Index registers carry one extra bit so n = DEPTH is representable.
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_RD_I, S_WAIT_I, S_RD_J, S_CMP, S_SWAP_A, S_SWAP_B, S_NEXT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         n_q, n_d;
  logic [IW-1:0]         i_q, i_d;
  logic [IW-1:0]         j_q, j_d;
  logic [IW-1:0]         min_idx_q, min_idx_d;
  logic [DATA_WIDTH-1:0] min_val_q, min_val_d;
  logic [DATA_WIDTH-1:0] a_i_q, a_i_d;
  logic [31:0]           cmp_cnt_q, cmp_cnt_d;
  logic [31:0]           swap_cnt_q, swap_cnt_d;
  logic                  lt;

  assign cmp_cnt  = cmp_cnt_q;
  assign swap_cnt = swap_cnt_q;

  // Strict less-than between the returned element and the running minimum.
  always_comb begin
    if (SIGNED != 0) lt = $signed(mem_rdata) < $signed(min_val_q);
    else             lt = mem_rdata < min_val_q;
  end

  // State and datapath registers; reset aborts any sort in progress.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      min_idx_q  <= '0;
      min_val_q  <= '0;
      a_i_q      <= '0;
      cmp_cnt_q  <= '0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      min_idx_q  <= min_idx_d;
      min_val_q  <= min_val_d;
      a_i_q      <= a_i_d;
      cmp_cnt_q  <= cmp_cnt_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // Next-state, datapath updates and RAM strobes decoded from the current state.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    min_idx_d  = min_idx_q;
    min_val_d  = min_val_q;
    a_i_d      = a_i_q;
    cmp_cnt_d  = cmp_cnt_q;
    swap_cnt_d = swap_cnt_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = (len > DEPTH_V) ? DEPTH_V : len;
          cmp_cnt_d  = '0;
          swap_cnt_d = '0;
          i_d        = '0;
          state_d    = (n_d < IW'(2)) ? S_DONE : S_RD_I;
        end
      end
      S_RD_I: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = i_q[ADDR_WIDTH-1:0];
        state_d   = S_WAIT_I;
      end
      S_WAIT_I: begin
        busy      = 1'b1;
        a_i_d     = mem_rdata;
        min_val_d = mem_rdata;
        min_idx_d = i_q;
        j_d       = i_q + IW'(1);
        state_d   = S_RD_J;
      end
      S_RD_J: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = j_q[ADDR_WIDTH-1:0];
        state_d   = S_CMP;
      end
      S_CMP: begin
        busy      = 1'b1;
        cmp_cnt_d = cmp_cnt_q + 32'd1;
        if (lt) begin
          min_val_d = mem_rdata;
          min_idx_d = j_q;
        end
        // The swap decision must see this cycle's minimum update, hence min_idx_d.
        if (j_q == n_q - IW'(1)) begin
          state_d = (min_idx_d != i_q) ? S_SWAP_A : S_NEXT;
        end else begin
          j_d     = j_q + IW'(1);
          state_d = S_RD_J;
        end
      end
      S_SWAP_A: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = min_idx_q[ADDR_WIDTH-1:0];
        mem_wdata = a_i_q;
        state_d   = S_SWAP_B;
      end
      S_SWAP_B: begin
        busy       = 1'b1;
        mem_wr_en  = 1'b1;
        mem_addr   = i_q[ADDR_WIDTH-1:0];
        mem_wdata  = min_val_q;
        swap_cnt_d = swap_cnt_q + 32'd1;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (i_q == n_q - IW'(2)) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = S_RD_I;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
